// File: rtl/t3_inc_sequencer.sv
// Round-robin share of one 16-trit balanced-ternary incrementer; request is applied +1 steps times, one per cycle.
// Response valid steps+1 cycles after accept (1 for steps=0 or illegal operand); no new grant until the response handshakes.
module t3_inc_sequencer #(
  parameter int NREQ = 4,
  parameter int CNTW = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic [NREQ-1:0]      I_req_valid,
  input  logic [NREQ*32-1:0]   I_req_a,
  input  logic [NREQ*CNTW-1:0] I_req_steps,
  output logic [NREQ-1:0]      O_req_ready,
  output logic                 O_rsp_valid,
  output logic [IDW-1:0]       O_rsp_id,
  output logic [31:0]          O_rsp_data,
  output logic                 O_rsp_ovf,
  output logic                 O_rsp_err,
  input  logic                 I_rsp_ready,
  output logic                 O_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [31:0]     acc;
  logic [CNTW-1:0] cnt;
  logic [IDW-1:0]  id;
  logic            ovf;
  logic            err;

  logic            grant_vld;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic [31:0]     sel_a;
  logic [CNTW-1:0] sel_steps;
  logic            sel_err;

  // Carry ripples through +1 trits (which wrap to -1); a 0 or -1 trit absorbs it.
  function automatic logic [31:0] t3_increment(input logic [31:0] a);
    logic [31:0] r;
    logic        c;
    r = a;
    c = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (c) begin
        case (a[2*i +: 2])
          2'b00:   begin r[2*i +: 2] = 2'b01; c = 1'b0; end
          2'b10:   begin r[2*i +: 2] = 2'b00; c = 1'b0; end
          2'b01:   r[2*i +: 2] = 2'b10;
          default: c = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!grant_vld && I_req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  assign sel_a     = I_req_a[32*int'(grant) +: 32];
  assign sel_steps = I_req_steps[CNTW*int'(grant) +: CNTW];

  always_comb begin
    sel_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sel_a[2*i +: 2] == 2'b11) sel_err = 1'b1;
    end
  end

  always_comb begin
    O_req_ready = '0;
    if (state == IDLE && grant_vld) O_req_ready[grant] = 1'b1;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      acc   <= '0;
      cnt   <= '0;
      id    <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            acc   <= sel_a;
            cnt   <= sel_steps;
            id    <= grant;
            ptr   <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
            ovf   <= 1'b0;
            err   <= sel_err;
            state <= (sel_err || sel_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc <= t3_increment(acc);
          cnt <= cnt - 1'b1;
          ovf <= ovf | (acc == 32'h5555_5555);
          if (cnt == CNTW'(1)) state <= DONE;
        end
        DONE: begin
          if (I_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_rsp_valid = (state == DONE);
  assign O_rsp_id    = id;
  assign O_rsp_data  = acc;
  assign O_rsp_ovf   = ovf;
  assign O_rsp_err   = err;
  assign O_busy      = (state != IDLE);

endmodule

// File: tb/tb_t3_inc_sequencer.sv
// Bench for t3_inc_sequencer: directed cases with literal results plus a random run
// compared every cycle against an arithmetic balanced-ternary reference.
module tb_t3_inc_sequencer;
  localparam int     NREQ = 4;
  localparam int     CNTW = 4;
  localparam longint TMAX = 64'd21523360;   // (3**16-1)/2
  localparam longint TMOD = 64'd43046721;   // 3**16

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*32-1:0]   req_a = '0;
  logic [NREQ*CNTW-1:0] req_steps = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_ovf;
  logic                 rsp_err;
  logic                 rsp_ready = 1'b1;
  logic                 busy;

  int n_chk = 0;
  int n_fail = 0;

  t3_inc_sequencer #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_req_valid(req_valid), .I_req_a(req_a), .I_req_steps(req_steps),
    .O_req_ready(req_ready),
    .O_rsp_valid(rsp_valid), .O_rsp_id(rsp_id), .O_rsp_data(rsp_data),
    .O_rsp_ovf(rsp_ovf), .O_rsp_err(rsp_err),
    .I_rsp_ready(rsp_ready), .O_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint t3_val(input logic [31:0] a);
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < 16; i++) begin
      if (a[2*i +: 2] == 2'b01) v = v + p;
      else if (a[2*i +: 2] == 2'b10) v = v - p;
      p = p * 3;
    end
    return v;
  endfunction

  function automatic logic [31:0] t3_enc(input longint v);
    logic [31:0] r = '0;
    longint      m;
    for (int i = 0; i < 16; i++) begin
      m = ((v % 3) + 3) % 3;
      if (m == 0) begin r[2*i +: 2] = 2'b00; v = v / 3; end
      else if (m == 1) begin r[2*i +: 2] = 2'b01; v = (v - 1) / 3; end
      else begin r[2*i +: 2] = 2'b10; v = (v + 1) / 3; end
    end
    return r;
  endfunction

  function automatic bit has_illegal(input logic [31:0] a);
    bit e = 1'b0;
    for (int i = 0; i < 16; i++) if (a[2*i +: 2] == 2'b11) e = 1'b1;
    return e;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one outstanding request at a time, result from plain integer arithmetic.
  bit          m_have;
  int          m_left;
  int          m_ptr;
  int          m_id;
  int          m_g;
  logic [31:0] m_data;
  bit          m_ovf;
  bit          m_err;
  logic [31:0] m_a;
  int          m_st;
  longint      m_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have = 1'b0; m_left = 0; m_ptr = 0;
    end else if (m_have) begin
      if (m_left > 0) m_left = m_left - 1;
      else if (rsp_ready) m_have = 1'b0;
    end else begin
      m_g = pick(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_a    = req_a[32*m_g +: 32];
        m_st   = int'(req_steps[CNTW*m_g +: CNTW]);
        m_id   = m_g;
        m_ptr  = (m_g + 1) % NREQ;
        m_err  = has_illegal(m_a);
        m_have = 1'b1;
        if (m_err) begin
          m_data = m_a; m_ovf = 1'b0; m_left = 0;
        end else begin
          m_s   = t3_val(m_a) + m_st;
          m_ovf = (m_s > TMAX);
          if (m_ovf) m_s = m_s - TMOD;
          m_data = t3_enc(m_s);
          m_left = m_st;
        end
      end
    end
  end

  task automatic compare_now();
    logic [NREQ-1:0] exp_rdy = '0;
    int  g;
    bit  exp_v;
    if (!m_have) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    exp_v = m_have && (m_left == 0);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_have);
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_ovf", rsp_ovf, m_ovf);
      chk("rsp_err", rsp_err, m_err);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) compare_now();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_req(input int k, input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] ed, input bit eo, input bit ee,
                        input int el, input string nm);
    bit seen = 1'b0;
    int lat = 0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_a[32*k +: 32] = a;
    req_steps[CNTW*k +: CNTW] = st;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (req_ready[k]) seen = 1'b1;
    end
    chk({nm, "_granted"}, seen, 1'b1);
    if (!seen) begin
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    chk({nm, "_rsp_seen"}, seen, 1'b1);
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_id"}, rsp_id, k);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_ovf"}, rsp_ovf, eo);
    chk({nm, "_err"}, rsp_err, ee);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int sel = $urandom_range(0, 9);
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0:       r[2*i +: 2] = 2'b00;
        1:       r[2*i +: 2] = 2'b01;
        default: r[2*i +: 2] = 2'b10;
      endcase
    end
    if (sel == 0) begin
      r[2*$urandom_range(0, 15) +: 2] = 2'b11;
    end else if (sel <= 2) begin
      r[31:4] = 28'h5555555;
      r[1:0]  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00;
      r[3:2]  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    end
    return r;
  endfunction

  logic [NREQ-1:0] rdy_seen;
  logic [NREQ-1:0] exp_oh;
  int              order [5] = '{0, 1, 2, 3, 0};
  bit              found;

  initial begin
    do_reset();
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", rsp_data, 32'h0);

    chk("pin_val", t3_val(32'h0000_001a), 64'd5);
    chk("pin_enc", t3_enc(64'd5), 32'h0000_001a);
    chk("pin_min", t3_val(32'haaaa_aaaa), -TMAX);

    do_req(0, 32'h0, 4'd1, 32'h1, 1'b0, 1'b0, 2, "t1");
    do_req(1, 32'h1555_5555, 4'd1, 32'h6aaa_aaaa, 1'b0, 1'b0, 2, "t2a");
    do_req(2, 32'h5555_5555, 4'd1, 32'haaaa_aaaa, 1'b1, 1'b0, 2, "t2b");
    do_req(3, 32'h0, 4'd3, 32'h4, 1'b0, 1'b0, 4, "t3a");
    do_req(0, 32'h6, 4'd0, 32'h6, 1'b0, 1'b0, 1, "t3b");
    do_req(1, 32'h3, 4'd5, 32'h3, 1'b0, 1'b1, 1, "t5");

    // All requesters valid at once straight out of reset.
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < NREQ; k++) begin
      req_a[32*k +: 32] = 32'h0;
      req_steps[CNTW*k +: CNTW] = CNTW'(k);
    end
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
        tick();
        if (|req_ready) found = 1'b1;
      end
      exp_oh = 4'b0001 << order[i];
      chk("t4_grant_order", req_ready, exp_oh);
      @(posedge clk); #1;
      if (i == 4) req_valid = '0;
    end
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (!busy) found = 1'b1;
    end
    chk("t4_drain", found, 1'b1);

    // Response held under backpressure while another requester waits.
    rsp_ready = 1'b0;
    do_req(2, 32'h0, 4'd3, 32'h4, 1'b0, 1'b0, 4, "t6");
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_a[31:0] = 32'h0;
    req_steps[CNTW-1:0] = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_data", rsp_data, 32'h4);
      chk("t6_hold_valid", rsp_valid, 1'b1);
      chk("t6_no_grant", req_ready, 4'b0000);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();

    // Reset in the middle of a long run.
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_a[63:32] = 32'h0;
    req_steps[2*CNTW-1:CNTW] = 4'd10;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (req_ready[1]) found = 1'b1;
    end
    chk("t6_run_grant", found, 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    tick();
    tick();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_data", rsp_data, 32'h0);
    chk("t6_rst_flags", {rsp_id, rsp_ovf, rsp_err}, 4'h0);
    chk("t6_rst_ready", req_ready, 4'b0000);
    tick();
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_steps = '0;
    req_a = '0;
    req_valid = 4'b1001;
    tick();
    chk("t6_ptr_reset", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic against the reference.
    rdy_seen = '0;
    for (int c = 0; c < 800; c++) begin
      tick();
      rdy_seen = req_ready;
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (rdy_seen[k]) begin
          req_valid[k] = 1'b0;
        end else if (req_valid[k]) begin
          if ($urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_a[32*k +: 32] = rand_op();
          req_steps[CNTW*k +: CNTW] = CNTW'($urandom_range(0, 15));
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (!busy) found = 1'b1;
    end
    chk("final_drain", found, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
